// File: rtl/sdram_responder_if.sv
// rtl/sdram_responder_if.sv - SDRAM pin bundle between controller (master) and responder (slave)
interface sdram_responder_if;
  logic        SDRAM_CKE;
  logic        SDRAM_nCS;
  logic        SDRAM_nRAS;
  logic        SDRAM_nCAS;
  logic        SDRAM_nWE;
  logic [1:0]  SDRAM_BA;
  logic [12:0] SDRAM_A;
  logic        SDRAM_DQML;
  logic        SDRAM_DQMH;
  logic [15:0] SDRAM_DQ_I;
  logic [15:0] SDRAM_DQ_O;
  logic        SDRAM_DQ_OE;

  modport master (
    output SDRAM_CKE, SDRAM_nCS, SDRAM_nRAS, SDRAM_nCAS, SDRAM_nWE,
    output SDRAM_BA, SDRAM_A, SDRAM_DQML, SDRAM_DQMH, SDRAM_DQ_I,
    input  SDRAM_DQ_O, SDRAM_DQ_OE
  );

  modport slave (
    input  SDRAM_CKE, SDRAM_nCS, SDRAM_nRAS, SDRAM_nCAS, SDRAM_nWE,
    input  SDRAM_BA, SDRAM_A, SDRAM_DQML, SDRAM_DQMH, SDRAM_DQ_I,
    output SDRAM_DQ_O, SDRAM_DQ_OE
  );
endinterface

// File: rtl/sdram_responder.sv
// rtl/sdram_responder.sv - SDRAM chip model: command decode, bank/timing tracking, storage, violation flags
module sdram_responder #(
  parameter int ROW_BITS = 4,
  parameter int COL_BITS = 9,
  parameter int TRCD     = 2,
  parameter int TRP      = 2,
  parameter int TRFC     = 7,
  parameter int TMRD     = 2
) (
  input  logic              clk,
  input  logic              init,
  sdram_responder_if.slave  bus,
  output logic              err,
  output logic [3:0]        err_code,
  output logic [15:0]       refresh_cnt
);
  localparam int AW = 2 + ROW_BITS + COL_BITS;
  localparam int TW = 8;

  typedef enum logic [2:0] {
    C_LMR = 3'b000, C_REF = 3'b001, C_PRE = 3'b010, C_ACT = 3'b011,
    C_WR  = 3'b100, C_RD  = 3'b101, C_NOP = 3'b111
  } cmd_t;

  cmd_t                cmd;
  logic [3:0]          code;
  logic [1:0]          ba;
  logic [12:0]         a;
  logic [AW-1:0]       addr;
  logic                mode_ok;
  logic [1:0]          cl;
  logic [3:0]          bank_open;
  logic [ROW_BITS-1:0] row [4];
  logic [TW-1:0]       trcd [4];
  logic [TW-1:0]       trp [4];
  logic [TW-1:0]       rfc;
  logic [TW-1:0]       mrd;
  logic [2:0]          pv;
  logic [15:0]         pd [3];
  logic                dq_oe;
  logic [15:0]         dq_o;
  logic                any_trp;
  logic                bad_mode;
  logic                accept;
  logic                wr_en;
  logic                unused_a;
  logic [15:0]         mem [2**AW];

  assign ba       = bus.SDRAM_BA;
  assign a        = bus.SDRAM_A;
  assign unused_a = &{1'b0, a};
  assign addr     = {ba, row[ba], a[COL_BITS-1:0]};
  assign bad_mode = !(a[6:4] == 3'd2 || a[6:4] == 3'd3) || (a[2:0] != 3'd0);
  assign accept   = (code == 4'd0) || (code == 4'd10);
  assign wr_en    = (cmd == C_WR) && accept;

  assign bus.SDRAM_DQ_O  = dq_o;
  assign bus.SDRAM_DQ_OE = dq_oe;

  always_comb begin
    cmd = C_NOP;
    if (bus.SDRAM_CKE && !bus.SDRAM_nCS) begin
      case ({bus.SDRAM_nRAS, bus.SDRAM_nCAS, bus.SDRAM_nWE})
        3'b000:  cmd = C_LMR;
        3'b001:  cmd = C_REF;
        3'b010:  cmd = C_PRE;
        3'b011:  cmd = C_ACT;
        3'b100:  cmd = C_WR;
        3'b101:  cmd = C_RD;
        default: cmd = C_NOP;
      endcase
    end
  end

  always_comb begin
    any_trp = 1'b0;
    for (int b = 0; b < 4; b++) any_trp = any_trp | (trp[b] != '0);
  end

  // Busy windows outrank every other check; a WR colliding with read output is still written.
  always_comb begin
    code = 4'd0;
    if (cmd != C_NOP) begin
      if (rfc != '0)      code = 4'd6;
      else if (mrd != '0) code = 4'd11;
      else begin
        case (cmd)
          C_ACT: begin
            if (!mode_ok)              code = 4'd1;
            else if (bank_open[ba])    code = 4'd2;
            else if (trp[ba] != '0)    code = 4'd5;
          end
          C_RD, C_WR: begin
            if (!mode_ok)              code = 4'd1;
            else if (!bank_open[ba])   code = 4'd3;
            else if (trcd[ba] != '0)   code = 4'd4;
            else if (cmd == C_WR && dq_oe) code = 4'd10;
          end
          C_REF: begin
            if (|bank_open)            code = 4'd7;
            else if (any_trp)          code = 4'd5;
          end
          C_LMR: begin
            if (|bank_open)            code = 4'd8;
            else if (any_trp)          code = 4'd5;
            else if (bad_mode)         code = 4'd9;
          end
          default: code = 4'd0;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      if (!bus.SDRAM_DQML) mem[addr][7:0]  <= bus.SDRAM_DQ_I[7:0];
      if (!bus.SDRAM_DQMH) mem[addr][15:8] <= bus.SDRAM_DQ_I[15:8];
    end
  end

  always_ff @(posedge clk or posedge init) begin
    if (init) begin
      err         <= 1'b0;
      err_code    <= 4'd0;
      refresh_cnt <= 16'd0;
      mode_ok     <= 1'b0;
      cl          <= 2'd0;
      bank_open   <= 4'd0;
      rfc         <= '0;
      mrd         <= '0;
      pv          <= 3'd0;
      dq_oe       <= 1'b0;
      dq_o        <= 16'd0;
      for (int b = 0; b < 4; b++) begin
        row[b]  <= '0;
        trcd[b] <= '0;
        trp[b]  <= '0;
      end
      for (int i = 0; i < 3; i++) pd[i] <= 16'd0;
    end else begin
      for (int b = 0; b < 4; b++) begin
        if (trcd[b] != '0) trcd[b] <= trcd[b] - 1'b1;
        if (trp[b] != '0)  trp[b]  <= trp[b] - 1'b1;
      end
      if (rfc != '0) rfc <= rfc - 1'b1;
      if (mrd != '0) mrd <= mrd - 1'b1;

      // Read pipeline: a read lands in stage CL-1 and leaves stage 0 onto DQ CL edges later.
      dq_oe <= pv[0];
      dq_o  <= pv[0] ? pd[0] : 16'd0;
      pv    <= {1'b0, pv[2:1]};
      pd[0] <= pd[1];
      pd[1] <= pd[2];

      if (code != 4'd0) begin
        err <= 1'b1;
        if (err_code == 4'd0) err_code <= code;
      end

      if (accept) begin
        case (cmd)
          C_ACT: begin
            bank_open[ba] <= 1'b1;
            row[ba]       <= a[ROW_BITS-1:0];
            trcd[ba]      <= TW'(TRCD - 1);
          end
          C_RD, C_WR: begin
            if (cmd == C_RD) begin
              pv[cl - 2'd1] <= 1'b1;
              pd[cl - 2'd1] <= mem[addr];
            end
            if (a[10]) begin
              bank_open[ba] <= 1'b0;
              trp[ba]       <= TW'(TRP + 1);
            end
          end
          C_PRE: begin
            for (int b = 0; b < 4; b++) begin
              if (bank_open[b] && (a[10] || ba == 2'(b))) begin
                bank_open[b] <= 1'b0;
                trp[b]       <= TW'(TRP - 1);
              end
            end
          end
          C_REF: begin
            refresh_cnt <= refresh_cnt + 16'd1;
            rfc         <= TW'(TRFC - 1);
          end
          C_LMR: begin
            mode_ok <= 1'b1;
            cl      <= a[5:4];
            mrd     <= TW'(TMRD - 1);
          end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_sdram_responder.sv
// tb/tb_sdram_responder.sv - directed table, hand sequences and randomized model check of sdram_responder
module tb_sdram_responder;
  localparam logic [2:0] K_LMR = 3'b000, K_REF = 3'b001, K_PRE = 3'b010, K_ACT = 3'b011;
  localparam logic [2:0] K_WR  = 3'b100, K_RD  = 3'b101, K_NOP = 3'b111;
  localparam int TRCD = 2, TRP = 2, TRFC = 7, TMRD = 2;

  logic        clk = 1'b0;
  logic        init = 1'b1;
  logic        err;
  logic [3:0]  err_code;
  logic [15:0] refresh_cnt;
  int checks = 0;
  int errors = 0;

  sdram_responder_if bus();

  sdram_responder dut (
    .clk(clk), .init(init), .bus(bus.slave),
    .err(err), .err_code(err_code), .refresh_cnt(refresh_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic step(input logic cke, input logic ncs, input logic [2:0] c, input logic [1:0] b,
                      input logic [12:0] a, input logic [1:0] m, input logic [15:0] d);
    bus.SDRAM_CKE = cke;
    bus.SDRAM_nCS = ncs;
    {bus.SDRAM_nRAS, bus.SDRAM_nCAS, bus.SDRAM_nWE} = c;
    bus.SDRAM_BA = b;
    bus.SDRAM_A = a;
    bus.SDRAM_DQMH = m[1];
    bus.SDRAM_DQML = m[0];
    bus.SDRAM_DQ_I = d;
    @(posedge clk);
    #1;
  endtask

  task automatic cmd(input logic [2:0] c, input logic [1:0] b, input logic [12:0] a,
                     input logic [1:0] m, input logic [15:0] d);
    step(1'b1, 1'b0, c, b, a, m, d);
  endtask

  task automatic nop();
    cmd(K_NOP, 2'd0, 13'd0, 2'b11, 16'd0);
  endtask

  task automatic do_reset();
    init = 1'b1;
    bus.SDRAM_CKE = 1'b1;
    bus.SDRAM_nCS = 1'b1;
    {bus.SDRAM_nRAS, bus.SDRAM_nCAS, bus.SDRAM_nWE} = K_NOP;
    @(posedge clk);
    #1;
    init = 1'b0;
  endtask

  // Reference model: absolute cycle numbers at which each command class becomes legal again.
  typedef struct { int due; logic [15:0] d; bit known; } rd_t;
  rd_t rq[$];
  logic [15:0] m_mem [int];
  int  m_n, m_cl, m_code, m_cnt, m_rfc_ok, m_mrd_ok;
  int  m_act_ok [4];
  int  m_rw_ok [4];
  int  m_row [4];
  bit  m_open [4];
  bit  m_mode, m_err, m_oe_prev;

  task automatic model_reset();
    rq.delete();
    m_n = 0; m_cl = 0; m_code = 0; m_cnt = 0; m_rfc_ok = 0; m_mrd_ok = 0;
    m_mode = 0; m_err = 0; m_oe_prev = 0;
    for (int i = 0; i < 4; i++) begin
      m_act_ok[i] = 0; m_rw_ok[i] = 0; m_row[i] = 0; m_open[i] = 0;
    end
  endtask

  task automatic model_step(input bit valid, input logic [2:0] c, input logic [1:0] b,
                            input logic [12:0] a, input logic [1:0] m, input logic [15:0] d,
                            output bit oe, output logic [15:0] q, output bit known);
    int code, addr, bi;
    bit any_open, any_trp;
    logic [2:0] cc;
    logic [15:0] w;
    rd_t e;
    bi = int'(b);
    cc = valid ? c : K_NOP;
    if (cc == 3'b110) cc = K_NOP;
    any_open = 0; any_trp = 0;
    for (int i = 0; i < 4; i++) begin
      any_open |= m_open[i];
      any_trp  |= (m_n < m_act_ok[i]);
    end
    addr = bi * 8192 + m_row[bi] * 512 + int'(a[8:0]);
    code = 0;
    if (cc != K_NOP) begin
      if (m_n < m_rfc_ok)      code = 6;
      else if (m_n < m_mrd_ok) code = 11;
      else if (cc == K_ACT) begin
        if (!m_mode) code = 1; else if (m_open[bi]) code = 2; else if (m_n < m_act_ok[bi]) code = 5;
      end else if (cc == K_RD || cc == K_WR) begin
        if (!m_mode) code = 1; else if (!m_open[bi]) code = 3;
        else if (m_n < m_rw_ok[bi]) code = 4; else if (cc == K_WR && m_oe_prev) code = 10;
      end else if (cc == K_REF) begin
        if (any_open) code = 7; else if (any_trp) code = 5;
      end else if (cc == K_LMR) begin
        if (any_open) code = 8; else if (any_trp) code = 5;
        else if (!(a[6:4] == 3'd2 || a[6:4] == 3'd3) || a[2:0] != 3'd0) code = 9;
      end
    end
    if (code != 0) begin
      m_err = 1;
      if (m_code == 0) m_code = code;
    end
    if (code == 0 || code == 10) begin
      case (cc)
        K_ACT: begin m_open[bi] = 1; m_row[bi] = int'(a[3:0]); m_rw_ok[bi] = m_n + TRCD; end
        K_RD, K_WR: begin
          if (cc == K_RD) begin
            e.due = m_n + m_cl; e.known = m_mem.exists(addr); e.d = e.known ? m_mem[addr] : 16'h0;
            rq.push_back(e);
          end else if (m == 2'b00) m_mem[addr] = d;
          else if (m_mem.exists(addr)) begin
            w = m_mem[addr];
            if (!m[0]) w[7:0] = d[7:0];
            if (!m[1]) w[15:8] = d[15:8];
            m_mem[addr] = w;
          end
          if (a[10]) begin m_open[bi] = 0; m_act_ok[bi] = m_n + TRP + 2; end
        end
        K_PRE: for (int i = 0; i < 4; i++)
                 if (m_open[i] && (a[10] || i == bi)) begin m_open[i] = 0; m_act_ok[i] = m_n + TRP; end
        K_REF: begin m_cnt = (m_cnt + 1) % 65536; m_rfc_ok = m_n + TRFC; end
        K_LMR: begin m_mode = 1; m_cl = int'(a[6:4]); m_mrd_ok = m_n + TMRD; end
        default: ;
      endcase
    end
    oe = 0; q = 16'h0; known = 0;
    foreach (rq[i]) if (rq[i].due == m_n) begin oe = 1; q = rq[i].d; known = rq[i].known; end
    while (rq.size() > 0 && rq[0].due <= m_n) void'(rq.pop_front());
    m_oe_prev = oe;
    m_n++;
  endtask

  task automatic rstep(input logic cke, input logic ncs, input logic [2:0] c, input logic [1:0] b,
                       input logic [12:0] a, input logic [1:0] m, input logic [15:0] d);
    bit eoe, kn;
    logic [15:0] eq;
    step(cke, ncs, c, b, a, m, d);
    model_step(cke && !ncs, c, b, a, m, d, eoe, eq, kn);
    chk("rnd_err", err, m_err);
    chk("rnd_code", err_code, m_code);
    chk("rnd_cnt", refresh_cnt, m_cnt);
    chk("rnd_oe", bus.SDRAM_DQ_OE, eoe);
    if (eoe && kn) chk("rnd_dq", bus.SDRAM_DQ_O, eq);
  endtask

  typedef struct {
    logic [2:0] c; logic [1:0] b; logic [12:0] a; logic [1:0] m; logic [15:0] d;
    int nops; logic e; logic [3:0] code; logic [15:0] cnt; int oe_at; logic [15:0] q;
  } vec_t;
  vec_t tbl [14];

  initial begin
    logic [2:0] c;
    logic [1:0] b, m;
    logic [12:0] a;
    logic [15:0] d;
    logic cke, ncs;
    int r;

    tbl[0]  = '{K_PRE, 2'd0, 13'h400, 2'b11, 16'h0,    0, 1'b0, 4'd0, 16'd0, -1, 16'h0};
    tbl[1]  = '{K_REF, 2'd0, 13'h000, 2'b11, 16'h0,    6, 1'b0, 4'd0, 16'd1, -1, 16'h0};
    tbl[2]  = '{K_REF, 2'd0, 13'h000, 2'b11, 16'h0,    6, 1'b0, 4'd0, 16'd2, -1, 16'h0};
    tbl[3]  = '{K_LMR, 2'd0, 13'h230, 2'b11, 16'h0,    1, 1'b0, 4'd0, 16'd2, -1, 16'h0};
    tbl[4]  = '{K_ACT, 2'd1, 13'h005, 2'b11, 16'h0,    1, 1'b0, 4'd0, 16'd2, -1, 16'h0};
    tbl[5]  = '{K_WR,  2'd1, 13'h412, 2'b00, 16'hA55A, 5, 1'b0, 4'd0, 16'd2, -1, 16'h0};
    tbl[6]  = '{K_ACT, 2'd1, 13'h005, 2'b11, 16'h0,    1, 1'b0, 4'd0, 16'd2, -1, 16'h0};
    tbl[7]  = '{K_RD,  2'd1, 13'h012, 2'b11, 16'h0,    4, 1'b0, 4'd0, 16'd2,  3, 16'hA55A};
    tbl[8]  = '{K_WR,  2'd1, 13'h020, 2'b00, 16'hFFFF, 0, 1'b0, 4'd0, 16'd2, -1, 16'h0};
    tbl[9]  = '{K_WR,  2'd1, 13'h020, 2'b10, 16'h1234, 0, 1'b0, 4'd0, 16'd2, -1, 16'h0};
    tbl[10] = '{K_RD,  2'd1, 13'h020, 2'b11, 16'h0,    3, 1'b0, 4'd0, 16'd2,  3, 16'hFF34};
    tbl[11] = '{K_ACT, 2'd2, 13'h003, 2'b11, 16'h0,    0, 1'b0, 4'd0, 16'd2, -1, 16'h0};
    tbl[12] = '{K_RD,  2'd2, 13'h000, 2'b11, 16'h0,    4, 1'b1, 4'd4, 16'd2, -1, 16'h0};
    tbl[13] = '{K_ACT, 2'd2, 13'h003, 2'b11, 16'h0,    0, 1'b1, 4'd4, 16'd2, -1, 16'h0};

    do_reset();
    chk("reset_err", err, 1'b0);
    chk("reset_code", err_code, 4'd0);
    chk("reset_cnt", refresh_cnt, 16'd0);
    chk("reset_oe", bus.SDRAM_DQ_OE, 1'b0);

    for (int i = 0; i < 14; i++) begin
      for (int k = 0; k <= tbl[i].nops; k++) begin
        if (k == 0) cmd(tbl[i].c, tbl[i].b, tbl[i].a, tbl[i].m, tbl[i].d);
        else nop();
        chk($sformatf("v%0d.%0d_err", i, k), err, tbl[i].e);
        chk($sformatf("v%0d.%0d_code", i, k), err_code, tbl[i].code);
        chk($sformatf("v%0d.%0d_cnt", i, k), refresh_cnt, tbl[i].cnt);
        chk($sformatf("v%0d.%0d_oe", i, k), bus.SDRAM_DQ_OE, k == tbl[i].oe_at);
        if (k == tbl[i].oe_at) chk($sformatf("v%0d.%0d_dq", i, k), bus.SDRAM_DQ_O, tbl[i].q);
      end
    end

    // REF then ACT three cycles later lands inside tRFC
    do_reset();
    cmd(K_REF, 2'd0, 13'h0, 2'b11, 16'h0);
    nop(); nop();
    cmd(K_ACT, 2'd0, 13'h0, 2'b11, 16'h0);
    chk("trfc_err", err, 1'b1);
    chk("trfc_code", err_code, 4'd6);

    do_reset();
    cmd(K_ACT, 2'd0, 13'h0, 2'b11, 16'h0);
    chk("nomode_code", err_code, 4'd1);

    // WR issued in the cycle the read word is on the bus: flagged, but still written
    do_reset();
    cmd(K_LMR, 2'd0, 13'h230, 2'b11, 16'h0); nop();
    cmd(K_ACT, 2'd0, 13'h000, 2'b11, 16'h0); nop();
    cmd(K_RD, 2'd0, 13'h030, 2'b11, 16'h0);
    nop(); nop(); nop();
    chk("cont_oe", bus.SDRAM_DQ_OE, 1'b1);
    cmd(K_WR, 2'd0, 13'h031, 2'b00, 16'hBEEF);
    chk("cont_code", err_code, 4'd10);
    chk("cont_oe_off", bus.SDRAM_DQ_OE, 1'b0);
    cmd(K_RD, 2'd0, 13'h031, 2'b11, 16'h0);
    nop(); nop(); nop();
    chk("cont_rd_oe", bus.SDRAM_DQ_OE, 1'b1);
    chk("cont_rd_dq", bus.SDRAM_DQ_O, 16'hBEEF);

    // Reset between a read command and its CAS-latency cycle
    do_reset();
    cmd(K_REF, 2'd0, 13'h0, 2'b11, 16'h0);
    for (int i = 0; i < 6; i++) nop();
    cmd(K_LMR, 2'd0, 13'h230, 2'b11, 16'h0); nop();
    cmd(K_ACT, 2'd0, 13'h000, 2'b11, 16'h0); nop();
    cmd(K_RD, 2'd0, 13'h031, 2'b11, 16'h0);
    nop();
    chk("prerst_cnt", refresh_cnt, 16'd1);
    init = 1'b1;
    #1;
    chk("rst_async_cnt", refresh_cnt, 16'd0);
    @(posedge clk); #1;
    init = 1'b0;
    for (int i = 0; i < 4; i++) begin
      nop();
      chk($sformatf("rst_oe%0d", i), bus.SDRAM_DQ_OE, 1'b0);
    end
    chk("rst_err", err, 1'b0);
    chk("rst_cnt", refresh_cnt, 16'd0);

    for (int seg = 0; seg < 30; seg++) begin
      do_reset();
      model_reset();
      rstep(1'b1, 1'b0, K_LMR, 2'd0, ($urandom_range(0, 1) == 0) ? 13'h230 : 13'h220, 2'b11, 16'h0);
      for (int k = 0; k < 40; k++) begin
        r = $urandom_range(0, 99);
        b = 2'($urandom_range(0, 3));
        a = 13'($urandom);
        m = 2'b11;
        d = 16'($urandom);
        cke = 1'b1; ncs = 1'b0;
        if (r < 30) begin
          c = 3'($urandom);
          case ($urandom_range(0, 2))
            0: c = K_NOP;
            1: cke = 1'b0;
            default: ncs = 1'b1;
          endcase
        end else if (r < 48) begin
          c = K_ACT; a[3:0] = 4'($urandom_range(0, 1));
        end else if (r < 80) begin
          c = (r < 64) ? K_RD : K_WR;
          a = 13'($urandom_range(0, 7));
          a[10] = ($urandom_range(0, 3) == 0);
          m = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00;
        end else if (r < 90) begin
          c = K_PRE;
        end else if (r < 95) begin
          c = K_REF;
        end else begin
          c = K_LMR;
          case ($urandom_range(0, 3))
            0: a = 13'h230;
            1: a = 13'h220;
            2: a = 13'h210;
            default: a = 13'h231;
          endcase
        end
        rstep(cke, ncs, c, b, a, m, d);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
